// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
package pipe_pkg;

  // Occupancy of the stage: no word, main register only, main plus skid.
  typedef enum logic [1:0] {ST_EMPTY, ST_HALF, ST_FULL} pipe_state_t;

  // Default width of the back-pressure counter.
  localparam int STALL_CNT_W = 8;

  // All-ones pattern; a counter of width w saturates at the low w bits of this.
  localparam logic [63:0] STALL_CNT_MAX_ALL = '1;

endpackage

// File: rtl/pipe_skid_buf.sv
// Storage and occupancy FSM of the elastic stage: main register plus,
// when PIPE_SKID_EN is defined, a second skid entry behind it.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              accept_i,
  input  logic              emit_i,
  input  logic [WIDTH-1:0]  data_i,
  output pipe_state_t       state_o,
  output logic [WIDTH-1:0]  data_o
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
`endif

  // Next occupancy and register contents; flush empties, hold freezes.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (!hold_i) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_i) begin
            state_d = ST_HALF;
            main_d  = data_i;
          end
        end
        ST_HALF: begin
          if (accept_i && emit_i) begin
            main_d = data_i;
`ifdef PIPE_SKID_EN
          end else if (accept_i) begin
            state_d = ST_FULL;
            skid_d  = data_i;
`else
          end else if (accept_i) begin
            main_d = data_i;
`endif
          end else if (emit_i) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        ST_FULL: begin
          if (emit_i) begin
            state_d = ST_HALF;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and main register; main resets to the configured idle value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_SKID_EN
  // Skid entry holds data only; its validity is carried by state_q.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end
`endif

  assign state_o = state_q;
  assign data_o  = main_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with hold, flush and a saturating
// back-pressure counter. Define PIPE_SKID_EN for a 2-entry skid buffer whose
// in_ready has no combinational path from out_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              hold,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = STALL_CNT_MAX_ALL[CNT_W-1:0];

  pipe_state_t      state;
  logic             has_word;
  logic             open_cyc;
  logic             accept;
  logic             emit;
  logic [CNT_W-1:0] stall_q, stall_d;

  pipe_skid_buf #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush_i  (flush),
    .hold_i   (hold),
    .accept_i (accept),
    .emit_i   (emit),
    .data_i   (in_data),
    .state_o  (state),
    .data_o   (out_data)
  );

  // A cycle with neither reset, flush nor hold may transfer words.
  assign has_word  = (state != ST_EMPTY);
  assign open_cyc  = reset_n && !hold && !flush;
  assign out_valid = open_cyc && has_word;
`ifdef PIPE_SKID_EN
  assign in_ready  = open_cyc && (state != ST_FULL);
`else
  assign in_ready  = open_cyc && (!has_word || out_ready);
`endif
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // Count cycles where a visible word is refused downstream; flush clears.
  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule
